plot_arbiter: RTL and testbench

- Shares the single VGA pixel-write port between N pixel-stream renderers: rect, text glyph, and a future image blitter.
- Round-robin arbitration, one grant per primitive. The grant is held from the first pixel to the `last` pixel, so primitives never interleave.
- Registered output stage drives the framebuffer write port.
- out_pause tells the HTML character stream to stall while any drawing is pending.

---
 rtl/plot_arbiter_pkg.sv | 21 ++
 rtl/plot_arbiter_rr_pick.sv | 31 +++
 rtl/plot_arbiter.sv | 143 ++++++++++++++
 tb/tb_plot_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_arbiter_pkg.sv
// plot_arbiter_pkg: shared widths, screen size, requester ids and FSM state encodings
// for the pixel-write arbiter.
package plot_arbiter_pkg;

  localparam int X_BITES       = 8;
  localparam int Y_BITES       = 7;
  localparam int COLOR_BITES   = 3;
  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;
  localparam int N_REQUESTERS  = 3;

  localparam int REQ_RECT = 0;
  localparam int REQ_TEXT = 1;
  localparam int REQ_IMG  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request searching upward from ptr+1.
// Zero latency, no state; found is low when no request is set.
module rr_pick
  import plot_arbiter_pkg::*;
#(
  parameter  int N    = N_REQUESTERS,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  logic [ID_W-1:0] cand;

  // k runs 1..N so the previous owner is considered last
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = ID_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin share of the framebuffer pixel port, grant held per primitive; PLOT_CLIP_EN drops off-screen beats.
// Latency 2 cycles valid->plot, 1 px/cycle in a burst; downstream never stalls, ready only to the owner.
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter  int N_REQ    = N_REQUESTERS,
  parameter  int X_W      = X_BITES,
  parameter  int Y_W      = Y_BITES,
  parameter  int C_W      = COLOR_BITES,
  parameter  int SCREEN_W = SCREEN_WIDTH,
  parameter  int SCREEN_H = SCREEN_HEIGHT,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_last,
  input  logic [N_REQ*X_W-1:0] req_x,
  input  logic [N_REQ*Y_W-1:0] req_y,
  input  logic [N_REQ*C_W-1:0] req_color,
  output logic [N_REQ-1:0]     req_ready,
  output logic [X_W-1:0]       out_x,
  output logic [Y_W-1:0]       out_y,
  output logic [C_W-1:0]       out_color,
  output logic                 plot,
  output logic                 out_pause,
  output logic [ID_W-1:0]      grant_id,
  output logic [15:0]          clip_count
);

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] color;
  } pix_t;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, gid_q, gid_d;
  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  pix_t            pix_q, pix_d, lane_pix;
  logic            plot_q, plot_d;
  logic            accept, clipped;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign lane_pix.x     = req_x[gid_q*X_W +: X_W];
  assign lane_pix.y     = req_y[gid_q*Y_W +: Y_W];
  assign lane_pix.color = req_color[gid_q*C_W +: C_W];

  // flush gates ready so a beat is never half-taken in the abort cycle
  assign accept = (state_q == ST_BURST) && !flush && req_valid[gid_q];

`ifdef PLOT_CLIP_EN
  logic [15:0] clip_q, clip_d;

  assign clipped = (int'(lane_pix.x) >= SCREEN_W) || (int'(lane_pix.y) >= SCREEN_H);

  always_comb begin
    clip_d = clip_q;
    if (accept && clipped && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) clip_q <= '0;
    else         clip_q <= clip_d;
  end

  assign clip_count = clip_q;
`else
  logic unused_screen;

  assign unused_screen = ^{SCREEN_W[0], SCREEN_H[0]};
  assign clipped       = 1'b0;
  assign clip_count    = '0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= ID_W'(N_REQ - 1);
      gid_q   <= '0;
      pix_q   <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      pix_q   <= pix_d;
      plot_q  <= plot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    pix_d   = pix_q;
    plot_d  = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            gid_d   = pick_idx;
            state_d = ST_BURST;
          end
        end
        ST_BURST: begin
          if (accept) begin
            plot_d = !clipped;
            if (!clipped) pix_d = lane_pix;
            if (req_last[gid_q]) begin
              state_d = ST_IDLE;
              ptr_d   = gid_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == ST_BURST) && !flush) req_ready[gid_q] = 1'b1;
  end

  assign out_x     = pix_q.x;
  assign out_y     = pix_q.y;
  assign out_color = pix_q.color;
  assign plot      = plot_q;
  assign grant_id  = gid_q;
  assign out_pause = (state_q == ST_BURST) | (|req_valid) | plot_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: scoreboard bench for plot_arbiter plus exhaustive check of rr_pick.
// Per-lane beat queues drive requesters; accepted beats are pushed and popped on plot.
module tb_plot_arbiter;
  import plot_arbiter_pkg::*;

  localparam int N = 3;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [1:0] id;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn, flush;
  logic [2:0]  req_valid, req_last, req_ready;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_color;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_color;
  logic        plot, out_pause;
  logic [1:0]  grant_id;
  logic [15:0] clip_count;
  logic [2:0]  pk_req;
  logic [1:0]  pk_ptr, pk_idx;
  logic        pk_found;

  always #5 clock = ~clock;

  plot_arbiter dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_last(req_last), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .req_ready(req_ready), .out_x(out_x), .out_y(out_y),
    .out_color(out_color), .plot(plot), .out_pause(out_pause), .grant_id(grant_id),
    .clip_count(clip_count)
  );

  rr_pick #(.N(N)) u_pick (.req(pk_req), .ptr(pk_ptr), .idx(pk_idx), .found(pk_found));

  int n_chk = 0, n_fail = 0;
  int cyc = 0, stall_lane = -1, stall_lo = -1, stall_hi = -1, flush_at = -1, exp_clip = 0;
  beat_t lane_q[N][$];
  exp_t  sb[$];
  logic       plot_h[$];
  logic       pause_h[$];
  logic [2:0] rdy_h[$];
  logic [1:0] gid_h[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic clip_model(input logic [7:0] x, input logic [6:0] y);
`ifdef PLOT_CLIP_EN
    return (int'(x) >= 160) || (int'(y) >= 120);
`else
    return 1'b0;
`endif
  endfunction

  function automatic beat_t mk(input int x, input int y, input int c, input bit last);
    beat_t b;
    b.x = 8'(x); b.y = 7'(y); b.c = 3'(c); b.last = last;
    return b;
  endfunction

  task automatic drive();
    req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_color = '0;
    flush = (cyc == flush_at);
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0) begin
        req_valid[i]         = !(i == stall_lane && cyc >= stall_lo && cyc <= stall_hi);
        req_last[i]          = lane_q[i][0].last;
        req_x[i*8 +: 8]      = lane_q[i][0].x;
        req_y[i*7 +: 7]      = lane_q[i][0].y;
        req_color[i*3 +: 3]  = lane_q[i][0].c;
      end
    end
  endtask

  task automatic cycle();
    logic [2:0] acc;
    exp_t e;
    @(negedge clock);
    plot_h.push_back(plot); pause_h.push_back(out_pause);
    rdy_h.push_back(req_ready); gid_h.push_back(grant_id);
    if (plot) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_plot", 32'(plot), 0);
      end else begin
        e = sb.pop_front();
        check_eq("out_x", 32'(out_x), 32'(e.x));
        check_eq("out_y", 32'(out_y), 32'(e.y));
        check_eq("out_color", 32'(out_color), 32'(e.c));
        check_eq("plot_owner", 32'(grant_id), 32'(e.id));
      end
    end
    acc = req_valid & req_ready;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (clip_model(lane_q[i][0].x, lane_q[i][0].y)) exp_clip++;
        else begin
          e.x = lane_q[i][0].x; e.y = lane_q[i][0].y; e.c = lane_q[i][0].c; e.id = 2'(i);
          sb.push_back(e);
        end
      end
    end
    @(posedge clock); #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(lane_q[i].pop_front());
    cyc++;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_hist();
    plot_h.delete(); pause_h.delete(); rdy_h.delete(); gid_h.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    sb.delete();
    stall_lane = -1; stall_lo = -1; stall_hi = -1; flush_at = -1; exp_clip = 0;
    clear_hist();
    drive();
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[4] = '{0, 1, 2, 0};
    beat_t cb[4];
    bit ef;
    int ei, c;

    resetn = 1'b0; flush = 1'b0;
    req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_color = '0;

    // rr_pick standalone, every pointer and request combination
    for (int p = 0; p < N; p++) begin
      for (int r = 0; r < 8; r++) begin
        pk_ptr = 2'(p); pk_req = 3'(r);
        #1;
        ef = 1'b0; ei = 0;
        for (int k = 1; k <= N; k++) begin
          c = (p + k) % N;
          if (!ef && r[c]) begin ef = 1'b1; ei = c; end
        end
        check_eq("pick_found", 32'(pk_found), 32'(ef));
        if (ef) check_eq("pick_idx", 32'(pk_idx), 32'(ei));
      end
    end

    // reset state
    do_reset();
    @(negedge clock);
    check_eq("rst_plot", 32'(plot), 0);
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_gid", 32'(grant_id), 0);
    check_eq("rst_clip", 32'(clip_count), 0);
    check_eq("rst_pause", 32'(out_pause), 0);
    check_eq("rst_out", 32'({out_x, out_y, out_color}), 0);
    @(posedge clock); #1;

    // all three single-pixel requesters: 0,1,2,0 with a bubble between
    clear_hist();
    lane_q[REQ_RECT].push_back(mk(1, 1, 1, 1));
    lane_q[REQ_RECT].push_back(mk(4, 4, 4, 1));
    lane_q[REQ_TEXT].push_back(mk(2, 2, 2, 1));
    lane_q[REQ_IMG].push_back(mk(3, 3, 3, 1));
    drive();
    run(10);
    check_eq("t1_pause", 32'(pause_h[0]), 1);
    check_eq("t1_no_plot_decision", 32'(plot_h[1]), 0);
    for (int k = 0; k < 4; k++) begin
      check_eq("t1_plot", 32'(plot_h[2 + 2*k]), 1);
      check_eq("t1_gid", 32'(gid_h[2 + 2*k]), 32'(order[k]));
    end
    for (int k = 0; k < 3; k++) check_eq("t1_bubble", 32'(plot_h[3 + 2*k]), 0);

    // rect burst with text held valid throughout
    do_reset();
    for (int k = 0; k < 4; k++) lane_q[REQ_RECT].push_back(mk(10 + k, 5, 4, k == 3));
    lane_q[REQ_TEXT].push_back(mk(50, 6, 2, 1));
    drive();
    run(9);
    for (int k = 2; k <= 5; k++) check_eq("t2_burst_plot", 32'(plot_h[k]), 1);
    for (int k = 0; k <= 5; k++) check_eq("t2_text_ready", 32'(rdy_h[k][REQ_TEXT]), 0);
    check_eq("t2_text_grant_ready", 32'(rdy_h[6]), 32'(3'b010));
    check_eq("t2_gap", 32'(plot_h[6]), 0);
    check_eq("t2_text_plot", 32'(plot_h[7]), 1);

    // owner drops valid for 3 cycles mid-burst
    do_reset();
    stall_lane = REQ_TEXT; stall_lo = 3; stall_hi = 5;
    for (int k = 0; k < 4; k++) lane_q[REQ_TEXT].push_back(mk(40 + k, 7, 5, k == 3));
    drive();
    run(10);
    for (int k = 4; k <= 6; k++) begin
      check_eq("t3_stall_plot", 32'(plot_h[k]), 0);
      check_eq("t3_stall_gid", 32'(gid_h[k]), 1);
      check_eq("t3_stall_ready", 32'(rdy_h[k]), 32'(3'b010));
    end
    check_eq("t3_resume", 32'(plot_h[7]), 1);
    check_eq("t3_resume2", 32'(plot_h[8]), 1);

    // flush the cycle after a beat is accepted
    do_reset();
    flush_at = 2;
    for (int k = 0; k < 3; k++) lane_q[REQ_RECT].push_back(mk(20 + k, 8, 6, k == 2));
    drive();
    run(8);
    check_eq("t4_inflight_plot", 32'(plot_h[2]), 1);
    check_eq("t4_flush_ready", 32'(rdy_h[2]), 0);
    check_eq("t4_idle_ready", 32'(rdy_h[3]), 0);
    check_eq("t4_idle_plot", 32'(plot_h[3]), 0);
    check_eq("t4_regrant", 32'(rdy_h[4]), 32'(3'b001));
    check_eq("t4_plot_after", 32'(plot_h[5]), 1);

    // async reset mid-burst, off the clock edge
    do_reset();
    for (int k = 0; k < 6; k++) lane_q[REQ_TEXT].push_back(mk(60 + k, 9, 7, k == 5));
    drive();
    run(3);
    check_eq("t5_pre_plot", 32'(plot), 1);
    check_eq("t5_pre_ready", 32'(req_ready), 32'(3'b010));
    #2 resetn = 1'b0;
    #1;
    check_eq("t5_async_plot", 32'(plot), 0);
    check_eq("t5_async_ready", 32'(req_ready), 0);
    check_eq("t5_async_gid", 32'(grant_id), 0);
    for (int i = 0; i < N; i++) lane_q[i].delete();
    sb.delete();
    drive();
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    clear_hist();
    lane_q[REQ_RECT].push_back(mk(70, 10, 1, 1));
    lane_q[REQ_TEXT].push_back(mk(71, 11, 2, 1));
    drive();
    run(6);
    check_eq("t5_first_plot", 32'(plot_h[2]), 1);
    check_eq("t5_first_gid", 32'(gid_h[2]), 0);
    check_eq("t5_second_gid", 32'(gid_h[4]), 1);

    // screen-edge beats inside one text burst
    do_reset();
    cb[0] = mk(170, 5, 3, 0);
    cb[1] = mk(159, 119, 2, 0);
    cb[2] = mk(160, 0, 1, 0);
    cb[3] = mk(0, 120, 4, 1);
    for (int k = 0; k < 4; k++) lane_q[REQ_TEXT].push_back(cb[k]);
    drive();
    run(7);
    for (int k = 0; k < 4; k++)
      check_eq("t6_clip_plot", 32'(plot_h[2 + k]), 32'(!clip_model(cb[k].x, cb[k].y)));
    check_eq("t6_clip_count", 32'(clip_count), 32'(exp_clip));
    flush_at = cyc;
    drive();
    run(2);
    check_eq("t6_clip_after_flush", 32'(clip_count), 32'(exp_clip));

    check_eq("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
